// File: rtl/t08_mem_arbiter.sv
// t08_mem_arbiter: round-robin sharing of one memory bus port between instruction fetch and data load/store.
// Optional bus_ack timeout (sticky timeout_err) is compiled in with `define T08_MEM_ARB_TIMEOUT_EN.
module t08_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        freeze,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

  state_t      state;
  grant_t      last_grant;
  logic [2:0]  op_funct3;
  logic [1:0]  op_lane;
  logic        d_req;
  logic        busy;
  logic        tmo;
  logic        done;
  logic [3:0]  sel_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic        unused_bits;

  assign d_req = d_read | d_write;
  assign busy  = (state != IDLE);
  assign done  = busy & (bus_ack | tmo);

  // Lane enables and replicated store data for the pending data request.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_next   = 4'b1111;
    wdata_next = d_wdata;
    case (d_funct3[1:0])
      2'b00: begin
        sel_next   = 4'b0001 << d_addr[1:0];
        wdata_next = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        sel_next   = d_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the size/lane captured at grant time.
  always_comb begin
    byte_lane = bus_rdata[{op_lane, 3'b000} +: 8];
    half_lane = op_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_funct3)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_data = {24'h0, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b101:  load_data = {16'h0, half_lane};
      default: load_data = bus_rdata;
    endcase
  end

  // Acks follow bus_ack in the same cycle; a timeout completes with zero data.
  assign i_ack   = (state == FETCH) & (bus_ack | tmo);
  assign d_ack   = (state == DATA)  & (bus_ack | tmo);
  assign i_rdata = (state == FETCH && bus_ack) ? bus_rdata : 32'h0;
  assign d_rdata = (state == DATA && bus_ack && !bus_write) ? load_data : 32'h0;
  assign freeze  = (i_req | d_read | d_write) & ~(i_ack | d_ack);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_DATA;
      bus_read   <= 1'b0;
      bus_write  <= 1'b0;
      bus_sel    <= 4'h0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      op_funct3  <= 3'b000;
      op_lane    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && (!d_req || last_grant == GRANT_DATA)) begin
            state    <= FETCH;
            bus_read <= 1'b1;
            bus_sel  <= 4'b1111;
            bus_addr <= {i_addr[31:2], 2'b00};
          end else if (d_req) begin
            // A store wins when the decoder raises both read and write.
            state     <= DATA;
            bus_read  <= ~d_write;
            bus_write <= d_write;
            bus_sel   <= sel_next;
            bus_addr  <= {d_addr[31:2], 2'b00};
            bus_wdata <= d_write ? wdata_next : 32'h0;
            op_funct3 <= d_funct3;
            op_lane   <= d_addr[1:0];
          end
        end
        FETCH, DATA: begin
          if (done) begin
            state      <= IDLE;
            last_grant <= (state == FETCH) ? GRANT_FETCH : GRANT_DATA;
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            bus_sel    <= 4'h0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef T08_MEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] wait_cnt;

  // Counter is zero in the first bus cycle after a grant.
  assign tmo = busy & ~bus_ack & (wait_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= busy ? wait_cnt + 1'b1 : '0;
      if (tmo) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign unused_bits = ^{i_addr[1:0], 32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_t08_mem_arbiter.sv
// Self-checking bench for t08_mem_arbiter: table-driven single transactions plus contention,
// reset-abort and (when compiled with T08_MEM_ARB_TIMEOUT_EN) timeout sequences.
module tb_t08_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_read;
  logic        d_write;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        freeze;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  t08_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_read(bus_read), .bus_write(bus_write), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .freeze(freeze), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        fetch;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  exp_sel;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        chk_rdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic fetch, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic [3:0] exp_sel,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rdata, input logic chk_rdata);
    vec_t v;
    v.name = name; v.fetch = fetch; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.exp_sel = exp_sel; v.exp_addr = exp_addr;
    v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata; v.chk_rdata = chk_rdata;
    return v;
  endfunction

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
    d_funct3 = 3'b000; d_addr = 32'h0; d_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk("fetch_100",   1, 0, 0, 3'b000, 32'h100, 32'h0,        32'h00500093, 4'hF, 32'h100,  32'h0,        32'h00500093, 1);
    vecs[1]  = mk("lb_sign",     0, 1, 0, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 4'h8, 32'h200,  32'h0,        32'hFFFFFF80, 1);
    vecs[2]  = mk("lbu_zero",    0, 1, 0, 3'b100, 32'h203, 32'h0,        32'h80FF1234, 4'h8, 32'h200,  32'h0,        32'h00000080, 1);
    vecs[3]  = mk("sh_upper",    0, 0, 1, 3'b001, 32'h12,  32'h0000BEEF, 32'h12345678, 4'hC, 32'h10,   32'hBEEFBEEF, 32'h0,        1);
    vecs[4]  = mk("lh_odd_up",   0, 1, 0, 3'b001, 32'h13,  32'h0,        32'h80FF1234, 4'hC, 32'h10,   32'h0,        32'hFFFF80FF, 1);
    vecs[5]  = mk("lhu_lower",   0, 1, 0, 3'b101, 32'h20,  32'h0,        32'h80FF9234, 4'h3, 32'h20,   32'h0,        32'h00009234, 1);
    vecs[6]  = mk("lb_lane1",    0, 1, 0, 3'b000, 32'h21,  32'h0,        32'h11227F44, 4'h2, 32'h20,   32'h0,        32'h0000007F, 1);
    vecs[7]  = mk("lw",          0, 1, 0, 3'b010, 32'h40,  32'h0,        32'hDEADBEEF, 4'hF, 32'h40,   32'h0,        32'hDEADBEEF, 1);
    vecs[8]  = mk("sb_lane1",    0, 0, 1, 3'b000, 32'h5,   32'h123456A5, 32'hFFFFFFFF, 4'h2, 32'h4,    32'hA5A5A5A5, 32'h0,        1);
    vecs[9]  = mk("sw",          0, 0, 1, 3'b010, 32'h8,   32'hCAFEF00D, 32'h0F0F0F0F, 4'hF, 32'h8,    32'hCAFEF00D, 32'h0,        1);
    vecs[10] = mk("rd_f3_011",   0, 1, 0, 3'b011, 32'h33,  32'h0,        32'h01020304, 4'hF, 32'h30,   32'h0,        32'h0,        0);
    vecs[11] = mk("rd_wr_both",  0, 1, 1, 3'b010, 32'h44,  32'h55AA55AA, 32'h99999999, 4'hF, 32'h44,   32'h55AA55AA, 32'h0,        1);
    vecs[12] = mk("fetch_1ffc",  1, 0, 0, 3'b000, 32'h1FFC, 32'h0,       32'h12345678, 4'hF, 32'h1FFC, 32'h0,        32'h12345678, 1);

    idle_inputs();
    reset = 1'b1;
    #12;
    check("rst_bus_read",  bus_read, 0);
    check("rst_bus_write", bus_write, 0);
    check("rst_bus_sel",   bus_sel, 0);
    check("rst_bus_addr",  bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_i_ack",     i_ack, 0);
    check("rst_d_ack",     d_ack, 0);
    check("rst_freeze",    freeze, 0);
    check("rst_tmo_err",   timeout_err, 0);
    reset = 1'b0;
    tick();

    // Single transactions: strobe one cycle after request, bus_ack one cycle after strobe.
    for (int k = 0; k < NV; k++) begin
      i_req    = vecs[k].fetch;
      d_read   = vecs[k].rd;
      d_write  = vecs[k].wr;
      d_funct3 = vecs[k].f3;
      d_wdata  = vecs[k].wdata;
      if (vecs[k].fetch) i_addr = vecs[k].addr;
      else               d_addr = vecs[k].addr;
      #1;
      check({vecs[k].name, "_freeze_req"}, freeze, 1);
      tick();
      check({vecs[k].name, "_bus_read"},  bus_read, vecs[k].fetch | (vecs[k].rd & ~vecs[k].wr));
      check({vecs[k].name, "_bus_write"}, bus_write, vecs[k].wr);
      check({vecs[k].name, "_bus_sel"},   bus_sel, vecs[k].exp_sel);
      check({vecs[k].name, "_bus_addr"},  bus_addr, vecs[k].exp_addr);
      if (vecs[k].wr) check({vecs[k].name, "_bus_wdata"}, bus_wdata, vecs[k].exp_wdata);
      check({vecs[k].name, "_no_ack_early"}, i_ack | d_ack, 0);
      tick();
      bus_ack = 1'b1;
      bus_rdata = vecs[k].rdata;
      #1;
      if (vecs[k].fetch) begin
        check({vecs[k].name, "_i_ack"},   i_ack, 1);
        check({vecs[k].name, "_d_ack0"},  d_ack, 0);
        check({vecs[k].name, "_i_rdata"}, i_rdata, vecs[k].exp_rdata);
      end else begin
        check({vecs[k].name, "_d_ack"},  d_ack, 1);
        check({vecs[k].name, "_i_ack0"}, i_ack, 0);
        if (vecs[k].chk_rdata) check({vecs[k].name, "_d_rdata"}, d_rdata, vecs[k].exp_rdata);
      end
      check({vecs[k].name, "_freeze_ack"}, freeze, 0);
      tick();
      idle_inputs();
      #1;
      check({vecs[k].name, "_strobe_drop"}, {bus_read, bus_write}, 0);
    end
    check("tmo_err_quiet", timeout_err, 0);

    // Contention from reset: fetch first (last_grant=DATA), one IDLE cycle, then data.
    tick();
    i_req = 1'b1; i_addr = 32'h100;
    d_read = 1'b1; d_funct3 = 3'b010; d_addr = 32'h80;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
    check("cont_first_read", bus_read, 1);
    check("cont_first_addr", bus_addr, 32'h100);
    check("cont_freeze1",    freeze, 1);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hAAAA0001;
    #1;
    check("cont_i_ack",   i_ack, 1);
    check("cont_d_ack0",  d_ack, 0);
    check("cont_i_rdata", i_rdata, 32'hAAAA0001);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h77777777;
    #1;
    check("idle_ack_ignored", {i_ack, d_ack}, 0);
    check("cont_idle_strobe", bus_read, 0);
    check("cont_freeze2",     freeze, 1);
    bus_ack = 1'b0;
    tick();
    check("cont_second_read", bus_read, 1);
    check("cont_second_addr", bus_addr, 32'h80);
    check("cont_freeze3",     freeze, 1);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h13579BDF;
    #1;
    check("cont_d_ack",   d_ack, 1);
    check("cont_i_ack0",  i_ack, 0);
    check("cont_d_rdata", d_rdata, 32'h13579BDF);
    tick();
    idle_inputs();
    #1;
    check("cont_done_strobe", bus_read, 0);

    // Reset while DATA awaits bus_ack: outputs clear at once, request is reissued afterwards.
    tick();
    d_read = 1'b1; d_funct3 = 3'b010; d_addr = 32'h90;
    tick();
    check("rmid_read", bus_read, 1);
    tick();
    check("rmid_wait_no_ack", d_ack, 0);
    #2;
    reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h5;
    #1;
    check("rmid_bus_read", bus_read, 0);
    check("rmid_bus_sel",  bus_sel, 0);
    check("rmid_bus_addr", bus_addr, 0);
    check("rmid_no_ack",   d_ack, 0);
    #2;
    reset = 1'b0; bus_ack = 1'b0;
    tick();
    check("rmid_reissue_read", bus_read, 1);
    check("rmid_reissue_addr", bus_addr, 32'h90);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hFEEDFACE;
    #1;
    check("rmid_d_ack",   d_ack, 1);
    check("rmid_d_rdata", d_rdata, 32'hFEEDFACE);
    tick();
    idle_inputs();

`ifdef T08_MEM_ARB_TIMEOUT_EN
    // No bus_ack: four wait cycles, then a zero-data ack and a sticky error flag.
    tick();
    d_read = 1'b1; d_funct3 = 3'b010; d_addr = 32'hA0; bus_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("tmo_wait_no_ack", d_ack, 0);
    end
    tick();
    check("tmo_d_ack",   d_ack, 1);
    check("tmo_d_rdata", d_rdata, 0);
    tick();
    check("tmo_err_set",      timeout_err, 1);
    check("tmo_strobe_drop",  bus_read, 0);
    idle_inputs();
    tick();
    tick();
    check("tmo_err_sticky", timeout_err, 1);
    reset = 1'b1;
    #1;
    check("tmo_err_reset", timeout_err, 0);
    reset = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
